// File: rtl/corelet_seq_ctrl_if.sv
// corelet_seq_ctrl_if: control, SRAM, L0 and ofifo signals between the corelet sequencer and its datapath
interface corelet_seq_ctrl_if #(
    parameter int KW      = 4,
    parameter int NW      = 7,
    parameter int AW_ADDR = 7,
    parameter int OP_ADDR = 9
);
    logic               seq_begin;
    logic [KW-1:0]      cfg_kij;
    logic [NW-1:0]      cfg_nij;
    logic               busy;
    logic               seq_done;
    logic [AW_ADDR-1:0] act_addr;
    logic               act_cen;
    logic [AW_ADDR-1:0] w_addr;
    logic               w_cen;
    logic               aw_sel;
    logic               l0_wr;
    logic               l0_rd;
    logic               l0_full;
    logic               l0_ready;
    logic [1:0]         inst_w;
    logic               array_clr;
    logic               ofifo_valid;
    logic               ofifo_rd;
    logic [OP_ADDR-1:0] op_addr;
    logic               op_cen;
    logic               op_wen;
    modport master (
        input  seq_begin, cfg_kij, cfg_nij, l0_full, l0_ready, ofifo_valid,
        output busy, seq_done, act_addr, act_cen, w_addr, w_cen, aw_sel, l0_wr, l0_rd,
               inst_w, array_clr, ofifo_rd, op_addr, op_cen, op_wen
    );
    modport slave (
        output seq_begin, cfg_kij, cfg_nij, l0_full, l0_ready, ofifo_valid,
        input  busy, seq_done, act_addr, act_cen, w_addr, w_cen, aw_sel, l0_wr, l0_rd,
               inst_w, array_clr, ofifo_rd, op_addr, op_cen, op_wen
    );
endinterface

// File: rtl/corelet_seq_ctrl.sv
// corelet_seq_ctrl: sequences weight load, execute, ofifo drain and psum write for each kernel position
module corelet_seq_ctrl #(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int KIJ_MAX = 9,
    parameter int NIJ_MAX = 64,
    parameter int AW_ADDR = 7,
    parameter int OP_ADDR = 9
) (
    input logic                clk,
    input logic                reset,
    corelet_seq_ctrl_if.master bus
);
    localparam int KW   = $clog2(KIJ_MAX + 1);
    localparam int CMAX = NIJ_MAX > ROW + COL ? NIJ_MAX : ROW + COL;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [3:0] {IDLE, W_LOAD, W_KERN, W_SETTLE, A_LOAD, A_EXEC, DRAIN, CLEAR, DONE} state_e;

    state_e             state_q, state_d;
    logic [KW-1:0]      kij_q, kij_d, cfg_kij_q, cfg_kij_d;
    logic [CW-1:0]      nij_q, nij_d, iss_q, iss_d, wr_q, wr_d, pop_q, pop_d, orq_q, orq_d, row_q, row_d;
    logic               busy_q, busy_d, done_q, done_d, l0_wr_q, l0_wr_d, l0_rd_q, l0_rd_d;
    logic               act_cen_q, act_cen_d, w_cen_q, w_cen_d, aw_sel_q, aw_sel_d;
    logic               clr_q, clr_d, ofifo_rd_q, ofifo_rd_d, op_cen_q, op_cen_d;
    logic [AW_ADDR-1:0] act_addr_q, act_addr_d, w_addr_q, w_addr_d;
    logic [OP_ADDR-1:0] op_addr_q, op_addr_d;
    logic [1:0]         inst_q, inst_d;

    always_comb begin
        state_d    = state_q;
        kij_d      = kij_q;
        cfg_kij_d  = cfg_kij_q;
        nij_d      = nij_q;
        iss_d      = iss_q;
        wr_d       = wr_q + CW'(l0_wr_q);
        pop_d      = pop_q;
        orq_d      = orq_q;
        row_d      = row_q + CW'(ofifo_rd_q);
        act_addr_d = act_addr_q;
        w_addr_d   = w_addr_q;
        act_cen_d  = 1'b1;
        w_cen_d    = 1'b1;
        // SRAM q arrives one cycle after cen, so the L0 write and mux select trail the read
        l0_wr_d    = !w_cen_q || !act_cen_q;
        aw_sel_d   = !w_cen_q ? 1'b1 : !act_cen_q ? 1'b0 : aw_sel_q;
        l0_rd_d    = 1'b0;
        inst_d     = 2'b00;
        clr_d      = 1'b0;
        ofifo_rd_d = 1'b0;
        op_cen_d   = !ofifo_rd_q;
        op_addr_d  = ofifo_rd_q ? OP_ADDR'(32'(kij_q) * 32'(nij_q) + 32'(row_q)) : op_addr_q;
        done_d     = state_q == DONE;
        if ((state_q == A_EXEC || state_q == DRAIN) && bus.ofifo_valid && orq_q < nij_q) begin
            ofifo_rd_d = 1'b1;
            orq_d      = orq_q + CW'(1);
        end
        case (state_q)
            IDLE: if (bus.seq_begin) begin
                cfg_kij_d = bus.cfg_kij;
                nij_d     = CW'(bus.cfg_nij);
                kij_d     = '0;
                state_d   = (bus.cfg_kij == '0 || bus.cfg_nij == '0) ? DONE : W_LOAD;
            end
            W_LOAD: begin
                if (iss_q < CW'(COL) && !bus.l0_full) begin
                    w_cen_d  = 1'b0;
                    w_addr_d = AW_ADDR'(32'(kij_q) * 32'(COL) + 32'(iss_q));
                    iss_d    = iss_q + CW'(1);
                end
                if (wr_q == CW'(COL)) state_d = W_KERN;
            end
            W_KERN: begin
                if (pop_q == CW'(COL)) state_d = W_SETTLE;
                else if (bus.l0_ready) begin
                    l0_rd_d = 1'b1;
                    inst_d  = 2'b01;
                    pop_d   = pop_q + CW'(1);
                end
            end
            W_SETTLE: begin
                pop_d = pop_q + CW'(1);
                if (pop_q == CW'(ROW + COL - 1)) state_d = A_LOAD;
            end
            A_LOAD: begin
                if (iss_q < nij_q && !bus.l0_full) begin
                    act_cen_d  = 1'b0;
                    act_addr_d = AW_ADDR'(iss_q);
                    iss_d      = iss_q + CW'(1);
                end
                if (wr_q == nij_q) state_d = A_EXEC;
            end
            A_EXEC: begin
                if (pop_q == nij_q) state_d = DRAIN;
                else if (bus.l0_ready) begin
                    l0_rd_d = 1'b1;
                    inst_d  = 2'b10;
                    pop_d   = pop_q + CW'(1);
                end
            end
            DRAIN: if (row_q == nij_q && !ofifo_rd_q) state_d = CLEAR;
            CLEAR: begin
                clr_d   = 1'b1;
                orq_d   = '0;
                row_d   = '0;
                state_d = kij_q == cfg_kij_q - KW'(1) ? DONE : W_LOAD;
                kij_d   = kij_q + KW'(1);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            iss_d = '0;
            wr_d  = '0;
            pop_d = '0;
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            kij_q      <= '0;
            cfg_kij_q  <= '0;
            nij_q      <= '0;
            iss_q      <= '0;
            wr_q       <= '0;
            pop_q      <= '0;
            orq_q      <= '0;
            row_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            l0_wr_q    <= 1'b0;
            l0_rd_q    <= 1'b0;
            act_cen_q  <= 1'b1;
            w_cen_q    <= 1'b1;
            aw_sel_q   <= 1'b1;
            clr_q      <= 1'b0;
            ofifo_rd_q <= 1'b0;
            op_cen_q   <= 1'b1;
            act_addr_q <= '0;
            w_addr_q   <= '0;
            op_addr_q  <= '0;
            inst_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            kij_q      <= kij_d;
            cfg_kij_q  <= cfg_kij_d;
            nij_q      <= nij_d;
            iss_q      <= iss_d;
            wr_q       <= wr_d;
            pop_q      <= pop_d;
            orq_q      <= orq_d;
            row_q      <= row_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            l0_wr_q    <= l0_wr_d;
            l0_rd_q    <= l0_rd_d;
            act_cen_q  <= act_cen_d;
            w_cen_q    <= w_cen_d;
            aw_sel_q   <= aw_sel_d;
            clr_q      <= clr_d;
            ofifo_rd_q <= ofifo_rd_d;
            op_cen_q   <= op_cen_d;
            act_addr_q <= act_addr_d;
            w_addr_q   <= w_addr_d;
            op_addr_q  <= op_addr_d;
            inst_q     <= inst_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.seq_done  = done_q;
    assign bus.act_addr  = act_addr_q;
    assign bus.act_cen   = act_cen_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.w_cen     = w_cen_q;
    assign bus.aw_sel    = aw_sel_q;
    assign bus.l0_wr     = l0_wr_q;
    assign bus.l0_rd     = l0_rd_q;
    assign bus.inst_w    = inst_q;
    assign bus.array_clr = clr_q;
    assign bus.ofifo_rd  = ofifo_rd_q;
    assign bus.op_addr   = op_addr_q;
    assign bus.op_cen    = op_cen_q;
    assign bus.op_wen    = op_cen_q;
endmodule

// File: tb/tb_corelet_seq_ctrl.sv
// tb_corelet_seq_ctrl: random-stall runs of the sequencer checked against per-run address/event lists
module tb_corelet_seq_ctrl;
    localparam int ROW = 8, COL = 8, KIJ_MAX = 9, NIJ_MAX = 64, AW_ADDR = 7, OP_ADDR = 9;
    localparam int KW = $clog2(KIJ_MAX + 1), NW = $clog2(NIJ_MAX + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0, errors = 0, cyc = 0, mode = 0, burst = 0, beg_cyc = 0, done_cyc = 0;
    int   w_seen, a_seen, op_seen, of_seen, clr_seen, done_seen, l0wr_seen;
    bit   mon_en = 1'b0;
    bit   p_full, p_ready, p_wcen = 1'b1, p_acen = 1'b1, p_ofv, p_ofrd;
    int   exp_w[$], exp_a[$], exp_op[$];
    bit   l0q[$];

    corelet_seq_ctrl_if #(.KW(KW), .NW(NW), .AW_ADDR(AW_ADDR), .OP_ADDR(OP_ADDR)) b();

    corelet_seq_ctrl #(.ROW(ROW), .COL(COL), .KIJ_MAX(KIJ_MAX), .NIJ_MAX(NIJ_MAX),
                       .AW_ADDR(AW_ADDR), .OP_ADDR(OP_ADDR)) dut (.clk(clk), .reset(reset), .bus(b.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // every kernel position reads all COL weights, then activations 0..n-1, then writes n psum rows
    task automatic build(input int k, input int n);
        exp_w.delete();
        exp_a.delete();
        exp_op.delete();
        if (k == 0 || n == 0) return;
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < COL; i++) exp_w.push_back((kk * COL + i) % (1 << AW_ADDR));
            for (int i = 0; i < n; i++) begin
                exp_a.push_back(i % (1 << AW_ADDR));
                exp_op.push_back((kk * n + i) % (1 << OP_ADDR));
            end
        end
    endtask

    initial begin
        b.l0_full = 1'b0;
        b.l0_ready = 1'b0;
        b.ofifo_valid = 1'b0;
        forever begin
            tick();
            if (mode == 0) begin
                b.l0_full = 1'b0;
                b.ofifo_valid = 1'b1;
                b.l0_ready = l0q.size() != 0;
            end else begin
                if (burst > 0) burst--;
                else if ($urandom_range(7) == 0) burst = 3;
                b.l0_full = burst > 0;
                b.l0_ready = l0q.size() != 0 && $urandom_range(2) != 0;
                b.ofifo_valid = $urandom_range(2) != 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (!b.w_cen) begin
                chk("w_read_while_full", p_full, 0);
                if (w_seen < exp_w.size()) chk("w_addr", b.w_addr, exp_w[w_seen]);
                w_seen++;
            end
            if (!b.act_cen) begin
                chk("act_read_while_full", p_full, 0);
                if (a_seen < exp_a.size()) chk("act_addr", b.act_addr, exp_a[a_seen]);
                a_seen++;
            end
            if (b.l0_rd) begin
                chk("l0_rd_ready", p_ready, 1);
                if (l0q.size() == 0) chk("l0_underflow", 0, 1);
                else chk("inst_w", b.inst_w, l0q.pop_front() ? 1 : 2);
            end else if (b.inst_w != 2'b00) chk("inst_idle", b.inst_w, 0);
            if (b.l0_wr || !p_wcen || !p_acen) begin
                chk("l0_wr", b.l0_wr, !p_wcen || !p_acen);
                if (b.l0_wr) begin
                    chk("aw_sel", b.aw_sel, !p_wcen);
                    l0q.push_back(b.aw_sel);
                    l0wr_seen++;
                end
            end
            if (b.ofifo_rd) begin
                chk("ofifo_rd_valid", p_ofv, 1);
                of_seen++;
            end
            if (!b.op_cen || p_ofrd) begin
                chk("op_wr", {b.op_cen, b.op_wen}, p_ofrd ? 0 : 3);
                if (!b.op_cen) begin
                    if (op_seen < exp_op.size()) chk("op_addr", b.op_addr, exp_op[op_seen]);
                    op_seen++;
                end
            end
            if (b.array_clr) clr_seen++;
            if (b.seq_done) begin
                chk("busy_at_done", b.busy, 0);
                done_seen++;
                done_cyc = cyc;
            end
        end
        p_full = b.l0_full;
        p_ready = b.l0_ready;
        p_wcen = b.w_cen;
        p_acen = b.act_cen;
        p_ofv = b.ofifo_valid;
        p_ofrd = b.ofifo_rd;
    end

    task automatic chk_rst();
        chk("rst_busy", b.busy, 0);
        chk("rst_done", b.seq_done, 0);
        chk("rst_l0", {b.l0_wr, b.l0_rd}, 0);
        chk("rst_inst", b.inst_w, 0);
        chk("rst_clr", b.array_clr, 0);
        chk("rst_ofifo_rd", b.ofifo_rd, 0);
        chk("rst_cen", {b.act_cen, b.w_cen, b.op_cen, b.op_wen}, 4'hf);
        chk("rst_addr", {b.act_addr, b.w_addr, b.op_addr}, 0);
        chk("rst_aw_sel", b.aw_sel, 1);
    endtask

    task automatic start_run(input int k, input int n, input int m);
        build(k, n);
        {w_seen, a_seen, op_seen, of_seen, clr_seen, done_seen, l0wr_seen} = '0;
        l0q.delete();
        mode = m;
        mon_en = 1'b1;
        b.cfg_kij = KW'(k);
        b.cfg_nij = NW'(n);
        b.seq_begin = 1'b1;
        beg_cyc = cyc;
        tick();
        b.seq_begin = 1'b0;
        chk("busy_start", b.busy, 1);
    endtask

    task automatic finish_run(input int k, input int n);
        int c = 0;
        while (done_seen == 0 && c < 20000) begin
            tick();
            c++;
        end
        if (done_seen == 0) chk("timeout", 0, 1);
        repeat (4) tick();
        chk("done_count", done_seen, 1);
        if (k == 0 || n == 0) chk("done_latency", done_cyc - beg_cyc, 2);
        chk("w_reads", w_seen, exp_w.size());
        chk("act_reads", a_seen, exp_a.size());
        chk("l0_writes", l0wr_seen, exp_w.size() + exp_a.size());
        chk("l0_left", l0q.size(), 0);
        chk("ofifo_pops", of_seen, exp_op.size());
        chk("op_writes", op_seen, exp_op.size());
        chk("clr_pulses", clr_seen, (k == 0 || n == 0) ? 0 : k);
        chk("busy_end", b.busy, 0);
    endtask

    initial begin
        b.seq_begin = 1'b0;
        b.cfg_kij = '0;
        b.cfg_nij = '0;
        repeat (2) tick();
        chk_rst();
        reset = 1'b0;
        tick();
        start_run(1, 4, 0);
        finish_run(1, 4);
        start_run(9, 36, 1);
        finish_run(9, 36);
        start_run(1, 0, 0);
        finish_run(1, 0);
        start_run(0, 5, 0);
        finish_run(0, 5);
        start_run(2, 6, 1);
        repeat (10) tick();
        b.cfg_kij = KW'(3);
        b.cfg_nij = NW'(5);
        b.seq_begin = 1'b1;
        tick();
        b.seq_begin = 1'b0;
        finish_run(2, 6);
        start_run(2, 8, 0);
        for (int c = 0; c < 3000 && b.inst_w != 2'b10; c++) tick();
        chk("reached_exec", b.inst_w, 2);
        mon_en = 1'b0;
        reset = 1'b1;
        tick();
        chk_rst();
        reset = 1'b0;
        tick();
        start_run(1, 4, 0);
        finish_run(1, 4);
        start_run(2, NIJ_MAX, 1);
        finish_run(2, NIJ_MAX);
        for (int r = 0; r < 4; r++) begin
            int k = $urandom_range(3, 1);
            int n = $urandom_range(20, 1);
            start_run(k, n, 1);
            finish_run(k, n);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
